// File: rtl/tx_char_framer_if.sv
// Link-side port bundle of the SpaceWire transmit character framer.
// The master drives permission and character requests; the slave (the
// framer) returns handshakes and the serial bit stream.
interface tx_char_framer_if;
    logic [1:0] mode;
    logic       fct_req;
    logic       fct_ack;
    logic       data_valid;
    logic [8:0] data_char;
    logic       data_ready;
    logic       tx_bit;
    logic       tx_active;

    modport master (
        output mode, fct_req, data_valid, data_char,
        input  fct_ack, data_ready, tx_bit, tx_active
    );

    modport slave (
        input  mode, fct_req, data_valid, data_char,
        output fct_ack, data_ready, tx_bit, tx_active
    );
endinterface

// File: rtl/tx_char_framer.sv
// SpaceWire transmit character framer.
// Picks FCT / N-char / NULL at each character boundary, attaches odd parity
// and shifts the character out LSB-first, one bit per tx_clk, without gaps.
//
// Channel state (no explicit FSM encoding; the bit counter is the state):
//   r_cnt == 0      | silent, tx_active low, every cycle is a boundary
//   r_cnt == 1      | last bit of a character on tx_bit (boundary)
//   r_cnt 2..10     | mid-character, bits still to come
module tx_char_framer (
    input  logic             tx_clk,
    input  logic             rst,
    tx_char_framer_if.slave  bus
);

    localparam logic [3:0] LEN_DATA = 4'd10;
    localparam logic [3:0] LEN_CTRL = 4'd4;
    localparam logic [3:0] LEN_NULL = 4'd8;

    logic [9:0] r_shift;
    logic [3:0] r_cnt;
    logic       r_active;
    logic       r_prev_x;

    logic       w_silent;
    logic       w_boundary;
    logic       w_can_pick;
    logic       w_sel_fct;
    logic       w_ready;
    logic       w_take_data;
    logic       w_marker_c1;
    logic       w_marker_c0;
    logic [9:0] w_load_vec;
    logic [3:0] w_load_len;
    logic       w_load_x;

    assign w_silent   = (r_cnt == 4'd0);
    assign w_boundary = (r_cnt <= 4'd1);

    // The first character out of silence is always a NULL, so FCT and
    // N-chars are only considered at boundaries of a running link.
    assign w_can_pick  = !rst && w_boundary && !w_silent;
    assign w_sel_fct   = w_can_pick && bus.mode[1] && bus.fct_req;
    assign w_ready     = w_can_pick && (bus.mode == 2'd3) && !(bus.mode[1] && bus.fct_req);
    assign w_take_data = w_ready && bus.data_valid;

    // Marker codes: EOP = c1c0 01, EEP = c1c0 10
    assign w_marker_c1 = bus.data_char[0];
    assign w_marker_c0 = ~bus.data_char[0];

    // Build the next character. Bit 0 goes out first (parity), bit 1 is the
    // flag, payload follows. Control parity = prev_x, data parity = ~prev_x.
    always_comb begin
        w_load_vec = {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, r_prev_x};
        w_load_len = LEN_NULL;
        w_load_x   = 1'b0;
        if (w_sel_fct) begin
            w_load_vec = {6'b000000, 1'b0, 1'b0, 1'b1, r_prev_x};
            w_load_len = LEN_CTRL;
            w_load_x   = 1'b0;
        end else if (w_take_data) begin
            if (bus.data_char[8]) begin
                w_load_vec = {6'b000000, w_marker_c0, w_marker_c1, 1'b1, r_prev_x};
                w_load_len = LEN_CTRL;
                w_load_x   = 1'b1;
            end else begin
                w_load_vec = {bus.data_char[7:0], 1'b0, ~r_prev_x};
                w_load_len = LEN_DATA;
                w_load_x   = ^bus.data_char[7:0];
            end
        end
    end

    // Shift/count datapath: load at boundaries, otherwise shift one bit out.
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            r_shift  <= 10'd0;
            r_cnt    <= 4'd0;
            r_active <= 1'b0;
            r_prev_x <= 1'b0;
        end else if (w_boundary) begin
            if (bus.mode == 2'd0) begin
                r_shift  <= 10'd0;
                r_cnt    <= 4'd0;
                r_active <= 1'b0;
                r_prev_x <= 1'b0;
            end else begin
                r_shift  <= w_load_vec;
                r_cnt    <= w_load_len;
                r_active <= 1'b1;
                r_prev_x <= w_load_x;
            end
        end else begin
            r_shift <= {1'b0, r_shift[9:1]};
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    assign bus.tx_bit     = r_shift[0];
    assign bus.tx_active  = r_active;
    assign bus.fct_ack    = w_sel_fct;
    assign bus.data_ready = w_ready;

endmodule

// File: tb/tb_tx_char_framer.sv
// Directed bench for tx_char_framer: hand-computed bit sequences per scenario.
module tb_tx_char_framer;

    logic tx_clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    tx_char_framer_if bus ();

    tx_char_framer dut (
        .tx_clk (tx_clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 tx_clk = ~tx_clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge tx_clk);
        #1;
    endtask

    // Record n cycles of outputs; element i is the i-th cycle observed.
    task automatic collect(input int n, output logic [31:0] bits, output logic [31:0] act,
                           output logic [31:0] rdy, output logic [31:0] ack);
        bits = '0; act = '0; rdy = '0; ack = '0;
        for (int i = 0; i < n; i++) begin
            bits[i] = bus.tx_bit;
            act[i]  = bus.tx_active;
            rdy[i]  = bus.data_ready;
            ack[i]  = bus.fct_ack;
            step();
        end
    endtask

    // Step until data_ready (sel_ack=0) or fct_ack (sel_ack=1) is high; bounded.
    task automatic wait_for(input bit sel_ack, output int n);
        n = 0;
        while (n < 20 && ((sel_ack ? bus.fct_ack : bus.data_ready) !== 1'b1)) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mode = 2'd0; bus.fct_req = 1'b0; bus.data_valid = 1'b0; bus.data_char = 9'h000;
        step(); step();
        checks++; if (bus.tx_bit !== 1'b0) begin errors++; $display("FAIL reset_tx_bit got=%b exp=0", bus.tx_bit); end
        checks++; if (bus.tx_active !== 1'b0) begin errors++; $display("FAIL reset_tx_active got=%b exp=0", bus.tx_active); end
        checks++; if (bus.fct_ack !== 1'b0) begin errors++; $display("FAIL reset_fct_ack got=%b exp=0", bus.fct_ack); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got=%b exp=0", bus.data_ready); end
    endtask

    // mode 1: NULLs only, FCT requests ignored.
    task automatic test_null();
        logic [31:0] b, a, r, k;
        rst = 1'b0; bus.mode = 2'd1; bus.fct_req = 1'b1;
        step();
        collect(16, b, a, r, k);
        bus.fct_req = 1'b0;
        checks++; if (b[15:0] !== 16'h2E2E) begin errors++; $display("FAIL null_bits got=%h exp=2e2e", b[15:0]); end
        checks++; if (a[15:0] !== 16'hFFFF) begin errors++; $display("FAIL null_active got=%h exp=ffff", a[15:0]); end
        checks++; if (r[15:0] !== 16'h0000) begin errors++; $display("FAIL null_ready got=%h exp=0000", r[15:0]); end
        checks++; if (k[15:0] !== 16'h0000) begin errors++; $display("FAIL null_ack got=%h exp=0000", k[15:0]); end
    endtask

    task automatic test_data_zero();
        logic [31:0] b, a, r, k;
        int n;
        bus.mode = 2'd3; bus.data_valid = 1'b1; bus.data_char = 9'h000;
        wait_for(1'b0, n);
        checks++; if (n != 7) begin errors++; $display("FAIL d0_accept_cycle got=%0d exp=7", n); end
        step();
        bus.data_valid = 1'b0;
        collect(18, b, a, r, k);
        checks++; if (b[9:0] !== 10'h001) begin errors++; $display("FAIL d0_bits got=%h exp=001", b[9:0]); end
        checks++; if (r[8:0] !== 9'h000) begin errors++; $display("FAIL d0_ready_mid got=%h exp=000", r[8:0]); end
        checks++; if (b[17:10] !== 8'h2E) begin errors++; $display("FAIL d0_null_bits got=%h exp=2e", b[17:10]); end
    endtask

    // data 0x001 then EOP back to back, then NULL with parity from prev_x=1.
    task automatic test_back_to_back();
        logic [31:0] b, a, r, k;
        int n;
        bus.data_valid = 1'b1; bus.data_char = 9'h001;
        wait_for(1'b0, n);
        checks++; if (n != 7) begin errors++; $display("FAIL b2b_accept_cycle got=%0d exp=7", n); end
        step();
        bus.data_char = 9'h100;
        collect(10, b, a, r, k);
        checks++; if (b[9:0] !== 10'h005) begin errors++; $display("FAIL b2b_data_bits got=%h exp=005", b[9:0]); end
        checks++; if (r[9:0] !== 10'h200) begin errors++; $display("FAIL b2b_ready got=%h exp=200", r[9:0]); end
        bus.data_valid = 1'b0;
        collect(12, b, a, r, k);
        checks++; if (b[11:0] !== 12'h2FB) begin errors++; $display("FAIL b2b_eop_null got=%h exp=2fb", b[11:0]); end
    endtask

    task automatic test_eep();
        logic [31:0] b, a, r, k;
        int n;
        bus.data_valid = 1'b1; bus.data_char = 9'h101;
        wait_for(1'b0, n);
        step();
        bus.data_valid = 1'b0;
        collect(12, b, a, r, k);
        checks++; if (n != 7 || b[11:0] !== 12'h2F6) begin
            errors++; $display("FAIL eep_null got=%h wait=%0d exp=2f6 wait=7", b[11:0], n);
        end
    endtask

    task automatic test_fct_priority();
        logic [31:0] b, a, r, k;
        int n;
        bus.fct_req = 1'b1; bus.data_valid = 1'b1; bus.data_char = 9'h0A5;
        wait_for(1'b1, n);
        checks++; if (n != 7) begin errors++; $display("FAIL fct_ack_cycle got=%0d exp=7", n); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL fct_blocks_ready got=%b exp=0", bus.data_ready); end
        step();
        bus.fct_req = 1'b0;
        collect(4, b, a, r, k);
        checks++; if (b[3:0] !== 4'h2) begin errors++; $display("FAIL fct_bits got=%h exp=2", b[3:0]); end
        checks++; if (k[3:0] !== 4'h0) begin errors++; $display("FAIL fct_ack_pulse got=%h exp=0", k[3:0]); end
        checks++; if (r[3:0] !== 4'h8) begin errors++; $display("FAIL fct_then_ready got=%h exp=8", r[3:0]); end
        bus.data_valid = 1'b0;
        collect(18, b, a, r, k);
        checks++; if (b[9:0] !== 10'h295) begin errors++; $display("FAIL fct_data_bits got=%h exp=295", b[9:0]); end
        checks++; if (b[17:10] !== 8'h2E) begin errors++; $display("FAIL fct_null_bits got=%h exp=2e", b[17:10]); end
    endtask

    task automatic test_mode2();
        logic [31:0] b, a, r, k;
        bus.mode = 2'd2; bus.data_valid = 1'b1; bus.data_char = 9'h0A5;
        collect(16, b, a, r, k);
        bus.data_valid = 1'b0;
        checks++; if (r[15:0] !== 16'h0000) begin errors++; $display("FAIL m2_ready got=%h exp=0000", r[15:0]); end
        checks++; if (b[15:0] !== 16'h2E2E) begin errors++; $display("FAIL m2_bits got=%h exp=2e2e", b[15:0]); end
    endtask

    task automatic test_silent();
        logic [31:0] b, a, r, k;
        int n;
        bus.mode = 2'd3; bus.data_valid = 1'b1; bus.data_char = 9'h100;
        wait_for(1'b0, n);
        step();
        bus.data_valid = 1'b0; bus.mode = 2'd0;
        collect(4, b, a, r, k);
        checks++; if (n != 7 || b[3:0] !== 4'hA || a[3:0] !== 4'hF) begin
            errors++; $display("FAIL sil_eop got=%h act=%h wait=%0d exp=a act=f wait=7", b[3:0], a[3:0], n);
        end
        checks++; if (bus.tx_active !== 1'b0 || bus.tx_bit !== 1'b0) begin
            errors++; $display("FAIL sil_enter got=%b%b exp=00", bus.tx_active, bus.tx_bit);
        end
        step(); step();
        checks++; if (bus.tx_active !== 1'b0 || bus.tx_bit !== 1'b0 || bus.data_ready !== 1'b0) begin
            errors++; $display("FAIL sil_hold got=%b%b%b exp=000", bus.tx_active, bus.tx_bit, bus.data_ready);
        end
        bus.mode = 2'd1;
        step();
        collect(8, b, a, r, k);
        checks++; if (b[7:0] !== 8'h2E || a[7:0] !== 8'hFF) begin
            errors++; $display("FAIL sil_exit got=%h act=%h exp=2e act=ff", b[7:0], a[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] b, a, r, k;
        int n;
        bus.mode = 2'd3; bus.data_valid = 1'b1; bus.data_char = 9'h07F;
        wait_for(1'b0, n);
        step();
        bus.data_valid = 1'b0;
        step(); step(); step(); step();
        checks++; if (n != 7 || bus.tx_bit !== 1'b1) begin
            errors++; $display("FAIL rm_bit5 got=%b wait=%0d exp=1 wait=7", bus.tx_bit, n);
        end
        rst = 1'b1; bus.mode = 2'd2;
        step();
        checks++; if ({bus.tx_bit, bus.tx_active, bus.data_ready, bus.fct_ack} !== 4'b0000) begin
            errors++; $display("FAIL rm_outputs got=%b%b%b%b exp=0000", bus.tx_bit, bus.tx_active, bus.data_ready, bus.fct_ack);
        end
        rst = 1'b0;
        step();
        collect(8, b, a, r, k);
        checks++; if (b[7:0] !== 8'h2E || a[7:0] !== 8'hFF) begin
            errors++; $display("FAIL rm_null got=%h act=%h exp=2e act=ff", b[7:0], a[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_null();
        test_data_zero();
        test_back_to_back();
        test_eep();
        test_fct_priority();
        test_mode2();
        test_silent();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
